reset_request_gen: RTL and testbench

- Collects reset-request sources (software request, debounced external push-button, internal watchdog) and drives a single active-low reset request to the system reset controller.
- Sits upstream of the system reset controller, on the always-on power-on reset (rst_n), so it is not cleared by the sys_rst_n it causes.
- Stretches each request to a minimum width, holds it until the controller acknowledges, then enforces a cooldown window.
- Records the cause of the last reset in a sticky register.

---
 rtl/reset_request_gen.sv | 177 +++++++++++++++++
 tb/tb_reset_request_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_request_gen.sv
// Reset-request generator: merges software, debounced push-button and watchdog
// events into one stretched, acknowledged, active-low reset request with a sticky cause.
module reset_request_gen #(
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned WDT_CYCLES   = 1000,
  parameter int unsigned PULSE_CYCLES = 8,
  parameter int unsigned COOL_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_req,
  input  logic       ext_btn_n,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  input  logic       rst_ack,
  input  logic       cause_clr,
  output logic       rst_req_n,
  output logic [2:0] cause,
  output logic       busy
);

  localparam int unsigned DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned WDT_W   = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam int unsigned PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned COOL_W  = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;
  localparam int unsigned PH_W    = (PULSE_W > COOL_W) ? PULSE_W : COOL_W;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_LAST   = WDT_W'(WDT_CYCLES - 1);
  localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0]  COOL_LAST  = PH_W'(COOL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_COOLDOWN = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PH_W-1:0]    ph_cnt_q, ph_cnt_d;
  logic [2:0]         cause_q, cause_d;
  logic               rst_req_n_q, rst_req_n_d;
  logic               busy_q, busy_d;

  logic               sw_req_q, sw_req_d;
  logic               btn_s1_q, btn_s1_d;
  logic               btn_s2_q, btn_s2_d;
  logic               btn_lvl_q, btn_lvl_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [WDT_W-1:0]   wdt_cnt_q, wdt_cnt_d;

  logic               sw_evt;
  logic               btn_evt;
  logic               wdt_evt;
  logic [2:0]         evt;

  // Software request: rising edge only, so a held request fires once.
  always_comb begin
    sw_req_d = sw_req;
    sw_evt   = sw_req & ~sw_req_q;
  end

  // Button: two-flop synchronizer, then a level debouncer; only a press fires.
  always_comb begin
    btn_s1_d  = ext_btn_n;
    btn_s2_d  = btn_s1_q;
    btn_lvl_d = btn_lvl_q;
    deb_cnt_d = '0;
    btn_evt   = 1'b0;
    if (btn_s2_q != btn_lvl_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_lvl_d = ~btn_lvl_q;
        btn_evt   = btn_lvl_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Watchdog only runs in IDLE; a kick in the expiry cycle suppresses the event.
  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    wdt_evt   = 1'b0;
    if (!wdt_en || (state_q != S_IDLE)) begin
      wdt_cnt_d = '0;
    end else if (wdt_kick) begin
      wdt_cnt_d = '0;
    end else if (wdt_cnt_q == WDT_LAST) begin
      wdt_evt   = 1'b1;
      wdt_cnt_d = '0;
    end else begin
      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    end
  end

  assign evt = {wdt_evt, btn_evt, sw_evt};

  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    cause_d  = cause_q;
    case (state_q)
      S_IDLE: begin
        if (evt != 3'b000) begin
          cause_d  = evt;
          ph_cnt_d = '0;
          state_d  = S_ASSERT;
        end else if (cause_clr) begin
          cause_d = 3'b000;
        end
      end
      S_ASSERT: begin
        if (ph_cnt_q == PULSE_LAST) begin
          ph_cnt_d = '0;
          state_d  = S_WAIT_ACK;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_WAIT_ACK: begin
        if (rst_ack) begin
          ph_cnt_d = '0;
          state_d  = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        if (ph_cnt_q == COOL_LAST) begin
          ph_cnt_d = '0;
          state_d  = S_IDLE;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      default: begin
        ph_cnt_d = '0;
        state_d  = S_IDLE;
      end
    endcase
    // Outputs are registered from the next state so they move with the state register.
    rst_req_n_d = ~((state_d == S_ASSERT) || (state_d == S_WAIT_ACK));
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ph_cnt_q    <= '0;
      cause_q     <= 3'b000;
      rst_req_n_q <= 1'b1;
      busy_q      <= 1'b0;
      sw_req_q    <= 1'b0;
      btn_s1_q    <= 1'b1;
      btn_s2_q    <= 1'b1;
      btn_lvl_q   <= 1'b1;
      deb_cnt_q   <= '0;
      wdt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      cause_q     <= cause_d;
      rst_req_n_q <= rst_req_n_d;
      busy_q      <= busy_d;
      sw_req_q    <= sw_req_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      btn_lvl_q   <= btn_lvl_d;
      deb_cnt_q   <= deb_cnt_d;
      wdt_cnt_q   <= wdt_cnt_d;
    end
  end

  assign rst_req_n = rst_req_n_q;
  assign cause     = cause_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reset_request_gen.sv
// Bench for reset_request_gen: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a timeline model of the request.
module tb_reset_request_gen;

  localparam int DEB   = 16;
  localparam int WDT   = 20;
  localparam int PULSE = 8;
  localparam int COOL  = 4;

  logic       clk;
  logic       rst_n;
  logic       sw_req;
  logic       ext_btn_n;
  logic       wdt_en;
  logic       wdt_kick;
  logic       rst_ack;
  logic       cause_clr;
  logic       rst_req_n;
  logic [2:0] cause;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  reset_request_gen #(
    .DEB_CYCLES  (DEB),
    .WDT_CYCLES  (WDT),
    .PULSE_CYCLES(PULSE),
    .COOL_CYCLES (COOL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_req   (sw_req),
    .ext_btn_n(ext_btn_n),
    .wdt_en   (wdt_en),
    .wdt_kick (wdt_kick),
    .rst_ack  (rst_ack),
    .cause_clr(cause_clr),
    .rst_req_n(rst_req_n),
    .cause    (cause),
    .busy     (busy)
  );

  // Clock and time limit
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL time_limit act=expired req=finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Reference model: a request is a timeline (start edge, release edge) rather than states.
  int         m_n, m_run, m_age, m_start, m_rel;
  bit         m_sw_prev, m_s1, m_s2, m_lvl, m_active, m_released;
  logic [2:0] m_ev;
  logic [2:0] m_cause;
  logic       m_req_n, m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_run = 0; m_age = 0; m_start = 0; m_rel = 0;
      m_sw_prev = 0; m_s1 = 1; m_s2 = 1; m_lvl = 1;
      m_active = 0; m_released = 0;
      m_cause = 3'b000; m_req_n = 1'b1; m_busy = 1'b0;
    end else begin
      m_n++;
      m_ev = 3'b000;
      m_ev[0] = sw_req && !m_sw_prev;
      m_sw_prev = sw_req;
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = !m_lvl;
          m_run = 0;
          m_ev[1] = !m_lvl;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = ext_btn_n;
      if (!wdt_en || m_active || wdt_kick) begin
        m_age = 0;
      end else begin
        m_age++;
        if (m_age == WDT) begin
          m_ev[2] = 1'b1;
          m_age = 0;
        end
      end
      if (!m_active) begin
        if (m_ev != 3'b000) begin
          m_active = 1; m_released = 0; m_start = m_n; m_cause = m_ev;
        end else if (cause_clr) begin
          m_cause = 3'b000;
        end
      end else if (!m_released) begin
        if ((m_n >= m_start + PULSE + 1) && rst_ack) begin
          m_released = 1; m_rel = m_n;
        end
      end else if (m_n >= m_rel + COOL) begin
        m_active = 0;
      end
      m_req_n = !(m_active && !m_released);
      m_busy  = m_active;
    end
  end

  // Per-cycle compare
  always @(negedge clk) begin
    n_vec++;
    if (rst_req_n !== m_req_n || busy !== m_busy || cause !== m_cause) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t act req_n=%b busy=%b cause=%b req req_n=%b busy=%b cause=%b",
               $time, rst_req_n, busy, cause, m_req_n, m_busy, m_cause);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d req=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_fall(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (rst_req_n && n <= max);
  endtask

  task automatic measure_low(output int n);
    n = 0;
    while (!rst_req_n && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic count_low(input int cyc, output int n);
    n = 0;
    repeat (cyc) begin
      tick();
      if (!rst_req_n) n++;
    end
  endtask

  task automatic kick();
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
  endtask

  // Directed scenarios, then random traffic
  initial begin
    int n, n0, n1, lows, hold;
    rst_n = 0; sw_req = 0; ext_btn_n = 1; wdt_en = 0; wdt_kick = 0; rst_ack = 0; cause_clr = 0;
    repeat (3) tick();
    check("reset_req_n", int'(rst_req_n), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_cause", int'(cause), 0);
    rst_n = 1;
    repeat (2) tick();

    // Software request, ack already high
    rst_ack = 1; sw_req = 1;
    wait_fall(50, n);
    check("sw_fall_latency", n, 1);
    check("sw_cause", int'(cause), 1);
    check("sw_busy", int'(busy), 1);
    measure_low(n);
    check("sw_low_width", n, PULSE + 1);
    measure_busy(n);
    check("sw_cool_width", n, COOL);
    count_low(20, n);
    check("sw_held_no_retrigger", n, 0);
    sw_req = 0;
    tick();

    // Button bounce then a real press
    ext_btn_n = 0; count_low(10, n0);
    ext_btn_n = 1; count_low(3, n1);
    check("btn_glitch_no_evt", n0 + n1, 0);
    ext_btn_n = 0;
    wait_fall(60, n);
    check("btn_latency", n, 2 + DEB);
    check("btn_cause", int'(cause), 2);
    measure_low(n);
    measure_busy(n);
    repeat (10) tick();
    ext_btn_n = 1;
    count_low(25, n);
    check("btn_release_no_evt", n, 0);

    // Watchdog kicked in time, kicked on the expiry cycle, then starved
    wdt_en = 1; lows = 0;
    for (int i = 0; i < 7; i++) begin
      kick(); count_low(14, n); lows += n;
    end
    check("wdt_kick15_no_evt", lows, 0);
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      kick(); count_low(19, n); lows += n;
    end
    check("wdt_kick_at_expiry", lows, 0);
    kick();
    wait_fall(60, n);
    check("wdt_timeout_latency", n, WDT);
    check("wdt_cause", int'(cause), 4);
    wdt_en = 0;
    measure_low(n);
    measure_busy(n);
    tick();

    // Simultaneous sw + wdt, dropped events, ack gating, clear rules
    rst_ack = 0; wdt_en = 1;
    kick();
    repeat (WDT - 1) tick();
    sw_req = 1;
    tick();
    wdt_en = 0;
    check("simul_fall", int'(rst_req_n), 0);
    check("simul_cause", int'(cause), 5);
    sw_req = 0;
    repeat (12) tick();
    sw_req = 1;
    tick(); tick();
    check("drop_wait_ack_cause", int'(cause), 5);
    count_low(36, n);
    check("ack_gate_hold", n, 36);
    rst_ack = 1;
    tick();
    check("ack_release_next_edge", int'(rst_req_n), 1);
    rst_ack = 0; cause_clr = 1; sw_req = 0;
    tick();
    sw_req = 1;
    measure_busy(n);
    check("ack_cool_width", n, COOL - 1);
    check("clr_ignored_busy", int'(cause), 5);
    cause_clr = 0;
    count_low(20, n);
    check("drop_no_new_req", n, 0);
    check("drop_cause_kept", int'(cause), 5);
    cause_clr = 1;
    tick();
    cause_clr = 0;
    check("clr_idle", int'(cause), 0);

    // Asynchronous reset while waiting for ack
    sw_req = 0; tick();
    sw_req = 1; rst_ack = 0;
    repeat (12) tick();
    check("pre_reset_low", int'(rst_req_n), 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_req_n", int'(rst_req_n), 1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_cause", int'(cause), 0);
    @(negedge clk);
    sw_req = 0;
    tick();
    rst_n = 1;
    tick();

    // Random traffic
    hold = 0; wdt_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sw_req = ~sw_req;
      if (hold == 0) begin
        ext_btn_n = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 40);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 199) == 0) wdt_en = ~wdt_en;
      wdt_kick  = ($urandom_range(0, 39) == 0);
      rst_ack   = ($urandom_range(0, 3) == 0);
      cause_clr = ($urandom_range(0, 19) == 0);
      tick();
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end
    end
    sw_req = 0; wdt_en = 0; wdt_kick = 0; rst_ack = 1; cause_clr = 0; ext_btn_n = 1;
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
